// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: Y = A - B - B_in, resolved CHUNK bits per cycle with a rippling borrow.
// Define SUBTRACTOR_FLAGS_EN to add the zero/neg/ovf result flags.
module serial_subtractor #(
  parameter int n     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         B_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] Y,
  output logic         B_out,
`ifdef SUBTRACTOR_FLAGS_EN
  output logic         zero,
  output logic         neg,
  output logic         ovf,
`endif
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // input side is ready only in IDLE, the result is offered only in DONE and
  // held stable until out_ready is seen.

  localparam int NCH  = n / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [n-1:0]    a_q, b_q, y_q;
  logic            borrow_q, b_out_q;
  logic [IDXW-1:0] idx_q;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = BUSY;
      BUSY:    if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    dbg_state = state_q;
  end

  // One chunk per BUSY cycle; the extra top bit of diff is the outgoing borrow.
  always_comb begin
    a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk = b_q[idx_q*CHUNK +: CHUNK];
    diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= B_in;
            idx_q    <= '0;
          end
        end
        BUSY: begin
          y_q[idx_q*CHUNK +: CHUNK] <= diff[CHUNK-1:0];
          borrow_q <= diff[CHUNK];
          if (idx_q == LAST) begin
            b_out_q <= diff[CHUNK];
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Y     = y_q;
  assign B_out = b_out_q;

`ifdef SUBTRACTOR_FLAGS_EN
  // Flags are qualified by out_valid so they read 0 out of reset and while busy.
  assign zero = out_valid && (y_q == '0);
  assign neg  = out_valid && y_q[n-1];
  assign ovf  = out_valid && (a_q[n-1] != b_q[n-1]) && (y_q[n-1] != a_q[n-1]);
`endif

endmodule
